// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded integer register file.
//   aw_f          : address width for a given register count
//   SP_IDX_DEF    : default index of the stack-pointer register (x2)
//   SP_RESET_DEF  : default reset value of the stack pointer
//   reg_idx_t     : register index type for the default 32-entry file
// No ports (package).
// ---------------------------------------------------------------------------
package regfile_pkg;

   function automatic int aw_f(input int num_regs);
      return $clog2(num_regs);
   endfunction

   localparam int          NUM_REGS_DEF = 32;
   localparam int          AW_DEF       = aw_f(NUM_REGS_DEF);
   localparam int          SP_IDX_DEF   = 2;
   localparam logic [31:0] SP_RESET_DEF = 32'h7FFF_FFFC;

   typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
// Decode / write-back side bus of the scoreboarded register file.
//   rs_i          : packed read addresses, port k at [k*AW +: AW]
//   rsdata_o      : packed read data, combinational
//   rsbusy_o      : per read port, addressed register has a write pending
//   rd_i/datawb_i : write-back destination and data
//   regwren_i     : write-back enable, also retires one pending write
//   issue_rd_i    : destination of the instruction being issued
//   issue_en_i    : mark issue_rd_i pending
//   issue_ready_o : issue_rd_i counter not saturated
//   flush_i       : clear all pending counters
// master = pipeline side, slave = register file.
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_RD*AW-1:0]     rs_i;
   logic [NUM_RD*DATA_W-1:0] rsdata_o;
   logic [NUM_RD-1:0]        rsbusy_o;
   logic [AW-1:0]            rd_i;
   logic [DATA_W-1:0]        datawb_i;
   logic                     regwren_i;
   logic [AW-1:0]            issue_rd_i;
   logic                     issue_en_i;
   logic                     issue_ready_o;
   logic                     flush_i;

   modport master (
      output rs_i, rd_i, datawb_i, regwren_i, issue_rd_i, issue_en_i, flush_i,
      input  rsdata_o, rsbusy_o, issue_ready_o
   );

   modport slave (
      input  rs_i, rd_i, datawb_i, regwren_i, issue_rd_i, issue_en_i, flush_i,
      output rsdata_o, rsbusy_o, issue_ready_o
   );
endinterface

// File: rtl/pending_counter.sv
// ---------------------------------------------------------------------------
// pending_counter
// Saturating up/down count of writes in flight for one register.
//   clk     : clock
//   rst     : asynchronous active-low reset (count -> 0)
//   inc_i   : issue to this register (ignored while saturated)
//   dec_i   : write-back to this register (ignored while count is 0)
//   flush_i : synchronous clear, wins over inc_i/dec_i
//   cnt_o   : current count
// ---------------------------------------------------------------------------
module pending_counter #(
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_i,
   input  logic              dec_i,
   input  logic              flush_i,
   output logic [PEND_W-1:0] cnt_o
);

   logic [PEND_W-1:0] cnt_q;
   logic [PEND_W-1:0] cnt_d;
   logic              inc_eff;
   logic              dec_eff;

   assign inc_eff = inc_i & (cnt_q != '1);
   assign dec_eff = dec_i & (cnt_q != '0);

   // An accepted issue and a retirement in the same cycle cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = '0;
      end else if (inc_eff && !dec_eff) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_eff && !inc_eff) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Integer register file with NUM_RD combinational read ports, one write-back
// port and a per-register pending-write scoreboard for RAW stall detection.
// x0 reads as zero and is never written or pending; SP_IDX resets to SP_RESET.
//   clk : clock, all state updates on rising edge
//   rst : asynchronous active-low reset
//   bus : regfile_scoreboard_if.slave (read, write-back, issue, flush)
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding
// of data and of the busy flag for the last outstanding write.
// ---------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                NUM_REGS = 32,
   parameter int                NUM_RD   = 2,
   parameter int                PEND_W   = 2,
   parameter int                SP_IDX   = SP_IDX_DEF,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_scoreboard_if.slave   bus
);

   localparam int                AW      = aw_f(NUM_REGS);
   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [PEND_W-1:0] cnt    [NUM_REGS];
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic [AW-1:0]     rs_addr [NUM_RD];
   logic              issue_go;
   logic              wb_go;

   assign wb_go    = bus.regwren_i & (bus.rd_i != '0);
   assign issue_go = bus.issue_en_i & bus.issue_ready_o & (bus.issue_rd_i != '0);

   assign bus.issue_ready_o = (bus.issue_rd_i == '0) | (cnt[bus.issue_rd_i] != CNT_MAX);

   // ---------------- storage ----------------
   always_comb begin
      regs_d = regs_q;
      if (wb_go) begin
         regs_d[bus.rd_i] = bus.datawb_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= (r == SP_IDX) ? SP_RESET : '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // ---------------- scoreboard ----------------
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue_go) begin
         inc_vec[bus.issue_rd_i] = 1'b1;
      end
      if (wb_go) begin
         dec_vec[bus.rd_i] = 1'b1;
      end
   end

   assign cnt[0] = '0;

   // inc_vec[0]/dec_vec[0] are never set (x0 has no counter instance).
   for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
      pending_counter #(
         .PEND_W (PEND_W)
      ) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .inc_i   (inc_vec[r]),
         .dec_i   (dec_vec[r]),
         .flush_i (bus.flush_i),
         .cnt_o   (cnt[r])
      );
   end

   // ---------------- read ports ----------------
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rs_addr[k] = bus.rs_i[k*AW +: AW];
      end
   end

   always_comb begin
      bus.rsdata_o = '0;
      bus.rsbusy_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (rs_addr[k] != '0) begin
            bus.rsdata_o[k*DATA_W +: DATA_W] = regs_q[rs_addr[k]];
            bus.rsbusy_o[k]                  = (cnt[rs_addr[k]] != '0);
`ifdef REGFILE_BYPASS_EN
            if (bus.regwren_i && (rs_addr[k] == bus.rd_i)) begin
               bus.rsdata_o[k*DATA_W +: DATA_W] = bus.datawb_i;
               // This write-back retires the only outstanding write, unless a
               // new write to the same register is being issued right now.
               if ((cnt[rs_addr[k]] == PEND_W'(1)) &&
                   !(issue_go && (bus.issue_rd_i == rs_addr[k]))) begin
                  bus.rsbusy_o[k] = 1'b0;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
   import regfile_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   regfile_scoreboard_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) rf_if ();

   regfile_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .bus (rf_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_rs(input reg_idx_t a0, input reg_idx_t a1);
      rf_if.rs_i = {a1, a0};
   endtask

   // Advance one clock; enables are one-shot pulses.
   task automatic step();
      @(posedge clk);
      #1;
      rf_if.regwren_i  = 1'b0;
      rf_if.issue_en_i = 1'b0;
      rf_if.flush_i    = 1'b0;
   endtask

   task automatic wb(input reg_idx_t r, input logic [31:0] d);
      rf_if.regwren_i = 1'b1;
      rf_if.rd_i      = r;
      rf_if.datawb_i  = d;
   endtask

   task automatic issue(input reg_idx_t r);
      rf_if.issue_en_i = 1'b1;
      rf_if.issue_rd_i = r;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      rf_if.rs_i       = '0;
      rf_if.rd_i       = '0;
      rf_if.datawb_i   = '0;
      rf_if.regwren_i  = 1'b0;
      rf_if.issue_rd_i = '0;
      rf_if.issue_en_i = 1'b0;
      rf_if.flush_i    = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      set_rs(5'd0, 5'd2);
      rf_if.issue_rd_i = 5'd7;
      #1;
      chk("rst_x0",    rf_if.rsdata_o[31:0],  32'h0);
      chk("rst_x2",    rf_if.rsdata_o[63:32], 32'h7FFF_FFFC);
      chk("rst_busy",  rf_if.rsbusy_o,        2'b00);
      chk("rst_ready", rf_if.issue_ready_o,   1'b1);
      rst = 1'b1;

      // Plain write and x0 protection
      step();
      wb(5'd5, 32'd123);
      step();
      set_rs(5'd5, 5'd0);
      #1;
      chk("x5_rd", rf_if.rsdata_o[31:0],  32'd123);
      chk("x0_rd", rf_if.rsdata_o[63:32], 32'h0);
      wb(5'd0, 32'd555);
      step();
      set_rs(5'd0, 5'd5);
      #1;
      chk("x0_wr555", rf_if.rsdata_o[31:0],  32'h0);
      chk("x5_keep",  rf_if.rsdata_o[63:32], 32'd123);

      // Saturate x7 (3 in flight), try a 4th issue
      step();
      for (int i = 0; i < 3; i++) begin
         rf_if.issue_rd_i = 5'd7;
         #1;
         chk("x7_rdy_pre", rf_if.issue_ready_o, 1'b1);
         issue(5'd7);
         step();
      end
      set_rs(5'd7, 5'd0);
      #1;
      chk("x7_sat_rdy",  rf_if.issue_ready_o, 1'b0);
      chk("x7_sat_busy", rf_if.rsbusy_o[0],   1'b1);
      issue(5'd7);
      step();
      #1;
      chk("x7_hold_busy", rf_if.rsbusy_o[0],   1'b1);
      chk("x7_hold_rdy",  rf_if.issue_ready_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         wb(5'd7, 32'd70 + 32'(i));
         step();
         #1;
         chk("x7_wb_busy", rf_if.rsbusy_o[0], (i < 2) ? 1'b1 : 1'b0);
         if (i == 0) chk("x7_wb_rdy", rf_if.issue_ready_o, 1'b1);
      end
      chk("x7_data", rf_if.rsdata_o[31:0], 32'd72);

      // Same-cycle issue + write-back on x9 with cnt=1
      issue(5'd9);
      step();
      issue(5'd9);
      wb(5'd9, 32'd99);
      step();
      set_rs(5'd9, 5'd0);
      #1;
      chk("x9_busy_same", rf_if.rsbusy_o[0],    1'b1);
      chk("x9_data",      rf_if.rsdata_o[31:0], 32'd99);
      wb(5'd9, 32'd100);
      step();
      #1;
      chk("x9_busy_clr", rf_if.rsbusy_o[0], 1'b0);

      // Write-back to x11 with no pending write: no underflow
      wb(5'd11, 32'hDEAD_BEEF);
      step();
      set_rs(5'd11, 5'd0);
      #1;
      chk("x11_data", rf_if.rsdata_o[31:0], 32'hDEAD_BEEF);
      chk("x11_busy", rf_if.rsbusy_o[0],    1'b0);
      issue(5'd11);
      step();
      #1;
      chk("x11_iss_busy", rf_if.rsbusy_o[0], 1'b1);
      wb(5'd11, 32'd1);
      step();
      #1;
      chk("x11_no_uflow", rf_if.rsbusy_o[0], 1'b0);

      // Flush beats a same-cycle issue; same-cycle write-back still lands
      issue(5'd3);
      step();
      issue(5'd4);
      step();
      issue(5'd31);
      step();
      set_rs(5'd3, 5'd4);
      #1;
      chk("pend_3_4", rf_if.rsbusy_o, 2'b11);
      rf_if.flush_i = 1'b1;
      issue(5'd6);
      wb(5'd20, 32'h2020);
      step();
      #1;
      chk("flush_3_4", rf_if.rsbusy_o, 2'b00);
      set_rs(5'd31, 5'd6);
      #1;
      chk("flush_31_6", rf_if.rsbusy_o, 2'b00);
      step();
      set_rs(5'd5, 5'd2);
      #1;
      chk("flush_x5", rf_if.rsdata_o[31:0],  32'd123);
      chk("flush_x2", rf_if.rsdata_o[63:32], 32'h7FFF_FFFC);
      set_rs(5'd20, 5'd7);
      #1;
      chk("flush_wb_x20", rf_if.rsdata_o[31:0],  32'h2020);
      chk("flush_x7",     rf_if.rsdata_o[63:32], 32'd72);

      // Same-cycle read of the register being written
      step();
      wb(5'd12, 32'h1111_1111);
      step();
      wb(5'd12, 32'hCAFE_BABE);
      set_rs(5'd12, 5'd0);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("x12_same", rf_if.rsdata_o[31:0], 32'hCAFE_BABE);
`else
      chk("x12_same", rf_if.rsdata_o[31:0], 32'h1111_1111);
`endif
      step();
      #1;
      chk("x12_next", rf_if.rsdata_o[31:0], 32'hCAFE_BABE);

      // Asynchronous reset mid-cycle
      issue(5'd13);
      step();
      set_rs(5'd13, 5'd5);
      #1;
      chk("x13_busy_pre", rf_if.rsbusy_o[0], 1'b1);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_busy", rf_if.rsbusy_o[0],     1'b0);
      chk("arst_x5",   rf_if.rsdata_o[63:32], 32'h0);
      step();
      set_rs(5'd2, 5'd7);
      #1;
      chk("arst_x2", rf_if.rsdata_o[31:0],  32'h7FFF_FFFC);
      chk("arst_x7", rf_if.rsdata_o[63:32], 32'h0);
      rst = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
